// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the op encodings, the op width, the control FSM state type and
// predicates that classify an op code.
package md_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed(input logic [OP_W-1:0] op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_acc(input logic [OP_W-1:0] op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_sub(input logic [OP_W-1:0] op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/md_seq_core.sv
// md_seq_core: bit-serial multiply/divide datapath.
// Runs a radix-2 shift-add multiply or a restoring divide on operand
// magnitudes, one bit per cycle for WIDTH cycles, then applies the sign fixup.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   load           - capture op/a/b and start counting (from top accept)
//   abort          - drop any in-flight iteration
//   op, a, b       - operation and operands
//   fin            - high during the cycle whose edge performs the last iteration
//   result         - sign-fixed 2*WIDTH result of that last iteration
//                    ({product} for multiplies, {remainder, quotient} for divides)
module md_seq_core
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 abort,
    input  logic [OP_W-1:0]      op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 fin,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             div_q, div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             bz_q, bz_d;

    logic             sgn_a_c, sgn_b_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [WIDTH:0]   mul_sum_c, div_shift_c, div_diff_c;
    logic [PW-1:0]    p_step_c;
    logic [WIDTH-1:0] quo_c, rem_c;

    assign fin = (cnt_q == CNT_W'(1));

    // One iteration plus the sign fixup applied to its outcome.
    always_comb begin
        sgn_a_c = is_signed(op) && a[WIDTH-1];
        sgn_b_c = is_signed(op) && b[WIDTH-1];
        a_mag_c = sgn_a_c ? -a : a;
        b_mag_c = sgn_b_c ? -b : b;

        // Multiply: p = {partial product, remaining multiplier bits}.
        mul_sum_c = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, opb_q} : '0);
        // Divide: p = {partial remainder, remaining dividend / quotient bits}.
        div_shift_c = p_q[PW-1:WIDTH-1];
        div_diff_c  = div_shift_c - {1'b0, opb_q};

        if (div_q) begin
            p_step_c = div_diff_c[WIDTH]
                     ? {div_shift_c[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                     : {div_diff_c[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b1};
        end else begin
            p_step_c = {mul_sum_c, p_q[WIDTH-1:1]};
        end

        // Divide by zero leaves the quotient at all ones; the remainder path
        // then naturally rebuilds the original dividend.
        rem_c = neg_a_q ? -p_step_c[PW-1:WIDTH] : p_step_c[PW-1:WIDTH];
        quo_c = ((neg_a_q ^ neg_b_q) && !bz_q) ? -p_step_c[WIDTH-1:0]
                                                : p_step_c[WIDTH-1:0];
        if (div_q) begin
            result = {rem_c, quo_c};
        end else begin
            result = (neg_a_q ^ neg_b_q) ? -p_step_c : p_step_c;
        end
    end

    // Operand capture and iteration control.
    always_comb begin
        cnt_d   = cnt_q;
        p_d     = p_q;
        opb_d   = opb_q;
        div_d   = div_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        bz_d    = bz_q;
        if (abort) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d   = CNT_W'(WIDTH);
            div_d   = is_div(op);
            neg_a_d = sgn_a_c;
            neg_b_d = sgn_b_c;
            bz_d    = (b == '0);
            p_d     = is_div(op) ? {WIDTH'(0), a_mag_c} : {WIDTH'(0), b_mag_c};
            opb_d   = is_div(op) ? b_mag_c : a_mag_c;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            p_d   = p_step_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            p_q     <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            bz_q    <= bz_d;
        end
    end

endmodule

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative multiply/divide unit owning HI/LO.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start, op, a, b - launch request, op code and operands
//   hi_we, lo_we    - direct writes HI <- a / LO <- a when idle
//   flush           - abort in-flight op, drop this cycle's start and writes
//   rd_sel, rdata   - combinational read of HI (0) or LO (1)
//   busy            - operation in flight
//   done            - one-cycle pulse after the edge that commits HI/LO
module md_iter_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             flush,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             done_q, done_d;

    logic             accept_c, commit_c, fin_c;
    logic [PW-1:0]    result_c, hilo_c, final_c;

    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign rdata    = rd_sel ? lo_q : hi_q;
    assign accept_c = start && !busy && !flush && (is_mul(op) || is_div(op));

    md_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept_c),
        .abort  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .fin    (fin_c),
        .result (result_c)
    );

    // Control FSM: flush in RUN wins over the final iteration.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        commit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_RUN;
                    op_d    = op;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (fin_c) begin
                    state_d  = S_IDLE;
                    commit_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = commit_c;
    end

    // HI/LO update: direct writes when idle, accumulate against HI/LO at commit.
    always_comb begin
        hilo_c  = {hi_q, lo_q};
        final_c = result_c;
        if (is_acc(op_q)) begin
            final_c = is_sub(op_q) ? hilo_c - result_c : hilo_c + result_c;
        end
        hi_d = hi_q;
        lo_d = lo_q;
        if (!busy && !flush) begin
            if (hi_we) hi_d = a;
            if (lo_we) lo_d = a;
        end
        if (commit_c) begin
            hi_d = final_c[PW-1:WIDTH];
            lo_d = final_c[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/md_iter_unit.md
# md_iter_unit

Parametrised iterative multiply/divide unit owning the HI/LO register pair. It sits in the EX stage of the pipelined core. It accepts signed and unsigned mult, div, multiply-add and multiply-subtract operations, and computes them one bit per cycle over WIDTH cycles. It holds `busy` while computing, supports direct HI/LO writes and reads, and can abort an in-flight operation on an exception/eret flush.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request to launch `op` with `a`, `b` this cycle.
- `op` in 4: operation code, from `md_pkg`.
- `a` in WIDTH: operand A (multiplicand / dividend); also the data for `hi_we`/`lo_we`.
- `b` in WIDTH: operand B (multiplier / divisor).
- `hi_we` in 1: mthi, loads HI ← `a`.
- `lo_we` in 1: mtlo, loads LO ← `a`.
- `flush` in 1: cancels the in-flight operation and suppresses this cycle's start and writes.
- `rd_sel` in 1: read select; 0 = HI, 1 = LO.
- `rdata` out WIDTH: combinational read of the selected register.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse on the edge that commits HI/LO.

## Operation
- Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU. Codes 9–15 are treated as NOP.
- Accept condition: `start && !busy && !flush && op` in 1..8. A start while busy is ignored; the pipeline must stall on `busy`.
- At accept, capture the operand magnitudes, the operand signs (signed ops only), the op, and load the counter with WIDTH.
- Multiply: radix-2 shift-add on magnitudes, producing a 2·WIDTH product.
  - Negate the product at the end if the signs differ (signed ops).
  - MULT/MULTU: {HI,LO} ← product.
  - MADD*: {HI,LO} ← {HI,LO} + product, mod 2^(2·WIDTH).
  - MSUB*: {HI,LO} ← {HI,LO} − product, mod 2^(2·WIDTH).
  - The accumulate uses HI/LO as they stand at commit.
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (truncating division).
  - LO ← quotient, HI ← remainder.
- Divide by zero: LO ← all ones, HI ← `a` as captured; no sign fixup.
- Signed MIN / −1: LO ← MIN, HI ← 0, the natural truncation of the magnitude path.
- `hi_we`/`lo_we` take effect only when `!busy && !flush`. If one coincides with an accepted start, the write lands first and a MADD/MSUB accumulates onto the written value.
- Flush while busy: abort, clear `busy` next edge, leave HI/LO untouched, no `done`.
- Flush while idle: drops that cycle's start and writes.
- Reset state: HI = 0, LO = 0, `busy` = 0, `done` = 0, counter = 0. Reset mid-operation discards the operation.
- States: IDLE → RUN on accept. RUN → IDLE when the counter reaches 1, with commit. RUN → IDLE on flush, without commit.

## Timing
- Accept at edge T: `busy` = 1 after T.
- Iterations run at edges T+1 .. T+WIDTH. The last iteration, sign fixup and accumulate all happen at edge T+WIDTH.
- At edge T+WIDTH: HI/LO committed, `busy` → 0, `done` = 1 for one cycle.
- Busy window is exactly WIDTH cycles; total latency from start to readable result is WIDTH+1 cycles.
- A new start is accepted in the cycle immediately after `done`, giving back-to-back throughput of one op per WIDTH+1 cycles.
- `rdata` reflects a register write in the cycle after the write edge; there is no bypass.

## Structure
- `md_pkg`: op encodings, `OP_W` = 4, and helper predicates `is_mul`, `is_div`, `is_signed`, `is_acc`, `is_sub`.
- Sub-module `md_seq_core`: the counter, the shift-add/restoring datapath and the sign fixup, producing a 2·WIDTH result plus a `fin` strobe.
- Top level: HI/LO registers, write arbitration, flush, read mux and the accumulate adder.

## Test plan
- MULT a = −3, b = 5 (WIDTH = 32) → `busy` high 32 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1, `done` pulses once.
- MULTU 0xFFFFFFFF × 2 → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 0x00000007.
- mtlo 0xFFFFFFFF, mthi 0, then MADDU 1 × 1 → HI = 1, LO = 0. Then MSUBU 1 × 1 → HI = 0, LO = 0xFFFFFFFF.
- DIV started, flush at busy cycle 10 → `busy` 0 next cycle, HI/LO unchanged, no `done`. Repeat with `reset` mid-op → HI = LO = 0, `busy` = 0 immediately. A start issued while busy is ignored.
